wb_accum_master: RTL and testbench
==================================

Name: wb_accum_master

Overview:
- Wishbone classic initiator that drives the add/sub accumulator's Wishbone responder.
- Takes a command word from a ready/valid command port and writes it as the packed operand word {op_a[31:16], op_b[15:0]}, with an optional skip of that write.
- Then reads back the result and returns it on a ready/valid response port.
- Sits between a local controller (test sequencer or on-chip FSM) and the accumulator's WB slave port; includes a no-ack timeout.

Parameters:
- SLV_ADDR, 32'h3000_0000, address driven on wbm_adr_o for both the write and the read.
- TIMEOUT, 16, number of consecutive stb-high cycles without ack before the transfer is aborted (legal range 2..255).
- TO_W, 8, width of the timeout counter.

Ports:
- wb_clk_i  in  1  single clock.
- wb_rst_n_i  in  1  reset, asynchronous, active-low.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted this cycle when high together with cmd_valid.
- cmd_wdata  in  32  operand word to write.
- cmd_skip_wr  in  1  1 = no write, read only.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed.
- rsp_data  out  32  read data (0 on error).
- rsp_err  out  1  transfer timed out.
- wbm_cyc_o  out  1  Wishbone cycle.
- wbm_stb_o  out  1  Wishbone strobe.
- wbm_we_o  out  1  Wishbone write enable.
- wbm_sel_o  out  4  Wishbone byte selects.
- wbm_adr_o  out  32  Wishbone address.
- wbm_dat_o  out  32  Wishbone write data.
- wbm_dat_i  in  32  Wishbone read data.
- wbm_ack_i  in  1  slave acknowledge.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset values (wb_rst_n_i low, takes effect immediately, asynchronous):
  - All outputs 0 except cmd_ready = 1; state IDLE.
  - Timeout counter 0; command and data registers 0.
  - Reset mid-transfer drops wbm_cyc_o/wbm_stb_o at once, with no completion and no response.
- All outputs are registered or decoded from state; no combinational path from wbm_ack_i to any output.
- FSM states: IDLE, WR, GAP, RD, RSP.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid, latch cmd_wdata and cmd_skip_wr.
  - Next state is RD if skip = 1, else WR.
- WR:
  - cyc = stb = we = 1, sel = 4'hF, adr = SLV_ADDR, dat_o = latched word.
  - On ack → GAP.
- GAP:
  - Exactly one cycle with cyc = stb = 0, then → RD.
  - Mandatory: the responder only acknowledges when its ack register is low, so stb must drop between beats.
- RD:
  - cyc = stb = 1, we = 0, sel = 4'hF, adr = SLV_ADDR, dat_o = 0.
  - On ack, capture wbm_dat_i into rsp_data, rsp_err = 0 → RSP.
- RSP:
  - rsp_valid = 1; rsp_data and rsp_err held stable until rsp_ready.
  - On rsp_ready → IDLE, rsp_valid = 0 next cycle.
  - cmd_ready = 0 throughout RSP.
- Timeout:
  - Counter clears on entry to WR or RD and increments every cycle in WR/RD without ack.
  - When the count reaches TIMEOUT-1 with no ack: drop cyc/stb next cycle, set rsp_data = 0 and rsp_err = 1, go to RSP.
  - A write timeout skips the read.
  - Ack in the same cycle as expiry: ack wins, normal completion.
- wbm_ack_i outside WR/RD is ignored.
- wbm_dat_i is sampled only on ack in RD.
- Latency with a responder that registers ack one cycle after seeing stb, counting from the accept edge:
  - Full write+read: rsp_valid high 5 cycles after accept.
  - Read only: 2 cycles after accept.
  - Back-to-back commands: minimum one IDLE cycle between RSP and the next WR/RD.

Decomposition:
- Shared package / header wb_master_pkg holds:
  - State encoding constants (IDLE = 0, WR = 1, GAP = 2, RD = 3, RSP = 4; 3-bit).
  - WB_SEL_ALL = 4'hF.
  - Default SLV_ADDR and TIMEOUT.
- No sub-module: the timeout counter and FSM are small enough to live in one module (~200 lines).

Test Plan:
- Add: cmd_wdata = 32'h0003_0005, skip = 0, responder nAdd_Sub = 0, use_prev_result = 0 → one write beat (dat_o = 32'h0003_0005), one GAP cycle, one read beat; rsp_data = 32'h0000_0008, rsp_err = 0, rsp_valid 5 cycles after accept.
- Subtract: cmd_wdata = 32'h0009_0004, nAdd_Sub = 1 → rsp_data = 32'h0000_0005.
- Read-only: skip = 1 after the previous command → no write beat (we never 1); rsp_data = 32'h0000_0005 (responder's stored operand recomputed); rsp_valid 2 cycles after accept.
- Backpressure: rsp_ready held low 3 cycles → rsp_valid/rsp_data stable, cmd_ready = 0, no WB activity; IDLE one cycle after rsp_ready.
- Timeout: responder ack tied 0 → stb high exactly 16 cycles then low, no read beat, rsp_err = 1, rsp_data = 0; then a normal command completes correctly.
- Reset mid-RD: wb_rst_n_i low during RD → wbm_cyc_o/wbm_stb_o 0 the same cycle (before the next edge), rsp_valid 0, cmd_ready 1 after release, no stale response afterward.

Source files
------------

// File: rtl/wb_accum_master_pkg.sv
// +--------------------------------------------------------------------------+
// | wb_master_pkg : shared encodings and defaults for wb_accum_master  rev 1.0 |
// +--------------------------------------------------------------------------+
`default_nettype none

package wb_master_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WR   = 3'd1,
    GAP  = 3'd2,
    RD   = 3'd3,
    RSP  = 3'd4
  } state_t;

  localparam logic [3:0]  WB_SEL_ALL   = 4'hF;
  localparam logic [31:0] DEF_SLV_ADDR = 32'h3000_0000;
  localparam int          DEF_TIMEOUT  = 16;
  localparam int          DEF_TO_W     = 8;

endpackage

`default_nettype wire

// File: rtl/wb_accum_master_if.sv
// +--------------------------------------------------------------------------+
// | wb_accum_master_if : Wishbone classic bus between master and responder    |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

interface wb_accum_master_if;
  import wb_master_pkg::*;

  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic [31:0] wbm_dat_i;
  logic        wbm_ack_i;

  modport master (
    output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
    input  wbm_dat_i, wbm_ack_i
  );

  modport slave (
    input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
    output wbm_dat_i, wbm_ack_i
  );

endinterface

`default_nettype wire

// File: rtl/wb_accum_master.sv
// +--------------------------------------------------------------------------+
// | wb_accum_master : command-driven write/read initiator for the accumulator |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module wb_accum_master
  import wb_master_pkg::*;
#(
  parameter logic [31:0] SLV_ADDR = DEF_SLV_ADDR,
  parameter int          TIMEOUT  = DEF_TIMEOUT,
  parameter int          TO_W     = DEF_TO_W
) (
  input  wire logic        wb_clk_i,
  input  wire logic        wb_rst_n_i,
  input  wire logic        cmd_valid,
  output logic             cmd_ready,
  input  wire logic [31:0] cmd_wdata,
  input  wire logic        cmd_skip_wr,
  output logic             rsp_valid,
  input  wire logic        rsp_ready,
  output logic [31:0]      rsp_data,
  output logic             rsp_err,
  output logic             busy,
  wb_accum_master_if.master wbm
);

  state_t            state, state_nxt;
  logic [31:0]       wdata_q;
  logic [TO_W-1:0]   to_cnt;
  logic [31:0]       rsp_data_q;
  logic              rsp_err_q;
  logic              in_wr, in_rd, in_bus, to_expired;

  assign in_wr      = (state == WR);
  assign in_rd      = (state == RD);
  assign in_bus     = in_wr | in_rd;
  assign to_expired = (to_cnt == TO_W'(TIMEOUT - 1));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (cmd_valid) state_nxt = cmd_skip_wr ? RD : WR;
      WR: begin
        if (wbm.wbm_ack_i)   state_nxt = GAP;
        else if (to_expired) state_nxt = RSP;
      end
      // stb must drop for a cycle so the responder's ack register can clear
      GAP: state_nxt = RD;
      RD: begin
        if (wbm.wbm_ack_i || to_expired) state_nxt = RSP;
      end
      RSP: if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state      <= IDLE;
      wdata_q    <= '0;
      to_cnt     <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && cmd_valid) wdata_q <= cmd_wdata;

      if ((state_nxt == WR || state_nxt == RD) && state_nxt != state)
        to_cnt <= '0;
      else if (in_bus && !wbm.wbm_ack_i)
        to_cnt <= to_cnt + 1'b1;

      // ack on the expiry cycle still completes normally
      if (in_rd && wbm.wbm_ack_i) begin
        rsp_data_q <= wbm.wbm_dat_i;
        rsp_err_q  <= 1'b0;
      end else if (in_bus && !wbm.wbm_ack_i && to_expired) begin
        rsp_data_q <= '0;
        rsp_err_q  <= 1'b1;
      end
    end
  end

  assign wbm.wbm_cyc_o = in_bus;
  assign wbm.wbm_stb_o = in_bus;
  assign wbm.wbm_we_o  = in_wr;
  assign wbm.wbm_sel_o = in_bus ? WB_SEL_ALL : 4'h0;
  assign wbm.wbm_adr_o = in_bus ? SLV_ADDR : 32'h0;
  assign wbm.wbm_dat_o = in_wr ? wdata_q : 32'h0;

  assign cmd_ready = (state == IDLE);
  assign rsp_valid = (state == RSP);
  assign busy      = (state != IDLE);
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;

endmodule

`default_nettype wire

// File: tb/tb_wb_accum_master.sv
// +--------------------------------------------------------------------------+
// | tb_wb_accum_master : scoreboard bench with a registered-ack accumulator   |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_wb_accum_master;
  import wb_master_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] cmd_wdata = '0;
  logic        cmd_skip_wr = 1'b0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  wb_accum_master_if bus();

  wb_accum_master dut (
    .wb_clk_i    (clk),
    .wb_rst_n_i  (rst_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_wdata   (cmd_wdata),
    .cmd_skip_wr (cmd_skip_wr),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .rsp_err     (rsp_err),
    .busy        (busy),
    .wbm         (bus)
  );

  // accumulator responder: ack one cycle after stb, only while ack is low
  logic        ack_q;
  logic        ack_en = 1'b1;
  logic        nadd_sub = 1'b0;
  logic [31:0] op_q = '0;
  int          wr_beats = 0, rd_beats = 0, stb_cyc = 0, we_cyc = 0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ack_q <= 1'b0;
    else        ack_q <= ack_en && bus.wbm_cyc_o && bus.wbm_stb_o && !ack_q;
  end

  always_ff @(posedge clk) begin
    if (bus.wbm_cyc_o && bus.wbm_stb_o && ack_q) begin
      if (bus.wbm_we_o) begin
        op_q     <= bus.wbm_dat_o;
        wr_beats <= wr_beats + 1;
      end else begin
        rd_beats <= rd_beats + 1;
      end
    end
    if (bus.wbm_stb_o) stb_cyc <= stb_cyc + 1;
    if (bus.wbm_we_o)  we_cyc  <= we_cyc + 1;
  end

  assign bus.wbm_ack_i = ack_q;
  assign bus.wbm_dat_i = nadd_sub ? {16'h0, op_q[31:16] - op_q[15:0]}
                                  : {16'h0, op_q[31:16] + op_q[15:0]};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] acc_result(input logic [31:0] op, input logic sub);
    logic [15:0] a, b;
    a = op[31:16];
    b = op[15:0];
    return sub ? {16'h0, a - b} : {16'h0, a + b};
  endfunction

  // scoreboard: {err, data}
  logic [32:0] exp_q[$];
  logic [31:0] model_op = '0;

  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        chk("rsp_data", rsp_data, e[31:0]);
        chk("rsp_err", {31'h0, rsp_err}, {31'h0, e[32]});
      end
    end
  end

  task automatic run_cmd(input logic [31:0] w, input logic skip, input logic exp_err,
                         output int lat);
    int n;
    if (!skip && !exp_err) model_op = w;
    exp_q.push_back({exp_err, exp_err ? 32'h0 : acc_result(model_op, nadd_sub)});
    @(posedge clk); #1;
    cmd_valid   = 1'b1;
    cmd_wdata   = w;
    cmd_skip_wr = skip;
    n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    lat = 0;
    @(negedge clk);
    while (!rsp_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    if (!rsp_valid) chk("rsp_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, wb0, rb0, sb0, wc0, vcount;
    logic [31:0] held;

    repeat (2) @(negedge clk);
    chk("rst_cmd_ready", {31'h0, cmd_ready}, 32'd1);
    chk("rst_cyc", {31'h0, bus.wbm_cyc_o}, 32'd0);
    chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'd0);
    chk("rst_busy", {31'h0, busy}, 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    rst_n = 1'b1;

    // add with write + read
    wb0 = wr_beats; rb0 = rd_beats;
    run_cmd(32'h0003_0005, 1'b0, 1'b0, lat);
    chk("add_latency", 32'(lat), 32'd5);
    @(posedge clk); #1;
    chk("add_wr_beats", 32'(wr_beats - wb0), 32'd1);
    chk("add_rd_beats", 32'(rd_beats - rb0), 32'd1);
    chk("add_wr_data", op_q, 32'h0003_0005);

    // subtract
    nadd_sub = 1'b1;
    run_cmd(32'h0009_0004, 1'b0, 1'b0, lat);
    chk("sub_latency", 32'(lat), 32'd5);
    @(posedge clk);

    // read only
    wb0 = wr_beats; rb0 = rd_beats; wc0 = we_cyc;
    run_cmd(32'hDEAD_BEEF, 1'b1, 1'b0, lat);
    chk("ro_latency", 32'(lat), 32'd2);
    @(posedge clk); #1;
    chk("ro_we_cycles", 32'(we_cyc - wc0), 32'd0);
    chk("ro_wr_beats", 32'(wr_beats - wb0), 32'd0);
    chk("ro_rd_beats", 32'(rd_beats - rb0), 32'd1);

    // backpressure
    nadd_sub  = 1'b0;
    rsp_ready = 1'b0;
    run_cmd(32'h0001_0002, 1'b0, 1'b0, lat);
    chk("bp_latency", 32'(lat), 32'd5);
    held = rsp_data;
    sb0  = stb_cyc;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_valid", {31'h0, rsp_valid}, 32'd1);
      chk("bp_data", rsp_data, held);
      chk("bp_cmd_ready", {31'h0, cmd_ready}, 32'd0);
      chk("bp_cyc", {31'h0, bus.wbm_cyc_o}, 32'd0);
    end
    chk("bp_stb_cycles", 32'(stb_cyc - sb0), 32'd0);
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("bp_idle_ready", {31'h0, cmd_ready}, 32'd1);
    chk("bp_idle_busy", {31'h0, busy}, 32'd0);

    // write timeout
    ack_en = 1'b0;
    sb0 = stb_cyc; rb0 = rd_beats;
    run_cmd(32'h0007_0001, 1'b0, 1'b1, lat);
    chk("to_latency", 32'(lat), 32'd16);
    chk("to_stb_cycles", 32'(stb_cyc - sb0), 32'd16);
    chk("to_stb_low", {31'h0, bus.wbm_stb_o}, 32'd0);
    @(posedge clk); #1;
    chk("to_rd_beats", 32'(rd_beats - rb0), 32'd0);
    ack_en = 1'b1;
    run_cmd(32'h0002_0002, 1'b0, 1'b0, lat);
    chk("post_to_latency", 32'(lat), 32'd5);
    @(posedge clk);

    // reset while the read is stalled
    ack_en = 1'b0;
    @(posedge clk); #1;
    cmd_valid   = 1'b1;
    cmd_skip_wr = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    chk("rd_active", {31'h0, bus.wbm_cyc_o}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_cyc", {31'h0, bus.wbm_cyc_o}, 32'd0);
    chk("rst_mid_stb", {31'h0, bus.wbm_stb_o}, 32'd0);
    chk("rst_mid_valid", {31'h0, rsp_valid}, 32'd0);
    @(negedge clk);
    rst_n  = 1'b1;
    ack_en = 1'b1;
    @(negedge clk);
    chk("rel_cmd_ready", {31'h0, cmd_ready}, 32'd1);
    vcount = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rsp_valid) vcount++;
    end
    chk("no_stale_rsp", 32'(vcount), 32'd0);
    run_cmd(32'h0, 1'b1, 1'b0, lat);
    chk("post_rst_latency", 32'(lat), 32'd2);
    @(posedge clk);
    @(negedge clk);

    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
